// File: rtl/serial_parity_rx_if.sv
// Serial bit stream in, assembled word plus parity/framing/reduction flags out.
interface serial_parity_rx_if #(
  parameter int DATA_W = 8
);
  logic              bit_in;
  logic              bit_valid;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              all_zero;
  logic              all_ones;
  logic              busy;

  modport master (
    output bit_in, bit_valid,
    input  data_out, data_valid, parity_err, frame_err, all_zero, all_ones, busy
  );

  modport slave (
    input  bit_in, bit_valid,
    output data_out, data_valid, parity_err, frame_err, all_zero, all_ones, busy
  );
endinterface

// File: rtl/serial_parity_rx.sv
// Start/data/parity/stop frame receiver; assembles DATA_W-bit words LSB first and
// reports parity, framing and all-zero/all-ones flags once per completed frame.
module serial_parity_rx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_parity_rx_if.slave   bus
);
  localparam int   CW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic POL = (PARITY_ODD != 0);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              last_bit;

  logic [DATA_W-1:0] data_q;
  logic              valid_q, perr_q, ferr_q, az_q, ao_q;

  assign last_bit = (cnt == CW'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.bit_valid) begin
      case (state)
        IDLE:    if (!bus.bit_in) state_nxt = DATA;
        DATA:    if (last_bit)    state_nxt = PAR;
        PAR:     state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Strobe-qualified datapath; gaps (bit_valid=0) freeze everything but the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      az_q    <= 1'b0;
      ao_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.bit_valid) begin
        case (state)
          IDLE: cnt <= '0;
          DATA: begin
            shreg <= {bus.bit_in, shreg[DATA_W-1:1]};
            cnt   <= cnt + 1'b1;
          end
          PAR:  par_bit <= bus.bit_in;
          STOP: begin
            data_q  <= shreg;
            perr_q  <= par_bit ^ (^shreg) ^ POL;
            ferr_q  <= ~bus.bit_in;
            az_q    <= ~|shreg;
            ao_q    <= &shreg;
            valid_q <= 1'b1;
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.all_zero   = az_q;
  assign bus.all_ones   = ao_q;
  assign bus.busy       = (state != IDLE);
endmodule
